fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipelined MIPS datapath.
- Owns the PC register and selects the next PC from the PCSrc encoding that the hazard unit arbitrates.
- Drives the icache request and owns the IF/ID pipeline latch.
- The hazard unit's PC_WEN and fd_state directly control this block; its latch outputs feed decode and the hazard unit's d_rs/d_rt/d_op extraction.

---
 rtl/fetch_stage.sv | 193 +++++++++++++++++++
 tb/tb_fetch_stage.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage pipelined MIPS datapath.
// Owns the PC, selects the next PC from the hazard unit's PCSrc, drives the
// icache request and holds the IF/ID pipeline latch.
// Optional build macro: FETCH_PERF_EN adds saturating fetch/bubble counters.

package fetch_pkg;
  // IF/ID latch control issued by the hazard unit.
  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2
  } pipe_state_t;
endpackage

module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] PC_INCR  = 32'd4
) (
  input  logic              CLK,
  input  logic              nRST,
  // icache interface
  input  logic              ihit,
  input  logic [31:0]       iload,
  output logic              imemREN,
  output logic [31:0]       imemaddr,
  // hazard unit / next-PC control
  input  logic              PC_WEN,
  input  logic [1:0]        PCSrc,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       jump_target,
  input  logic [31:0]       jr_target,
  input  pipe_state_t       fd_state,
  input  logic              halt_in,
  // IF/ID latch outputs
  output logic [31:0]       fd_instr,
  output logic [31:0]       fd_pc,
  output logic [31:0]       fd_npc,
  output logic              fd_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles
`endif
);

  localparam logic [1:0] SRC_SEQ    = 2'd0;
  localparam logic [1:0] SRC_BRANCH = 2'd1;
  localparam logic [1:0] SRC_JUMP   = 2'd2;
  localparam logic [1:0] SRC_JR     = 2'd3;

  // Architectural state
  logic [31:0] pc_q, pc_d;
  logic        halted_q, halted_d;

  // IF/ID latch
  logic [31:0] fd_instr_q, fd_instr_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_npc_q, fd_npc_d;
  logic        fd_valid_q, fd_valid_d;

  // Sequential successor of the current PC (32-bit modulo, wraps to 0)
  logic [31:0] npc;

  // Event strobes for this edge, used by the optional counters
  logic        load_valid;
  logic        load_bubble;

  assign npc      = pc_q + PC_INCR;
  // Targets are stored unaligned; alignment is applied only toward the icache.
  assign imemaddr = {pc_q[31:2], 2'b00};
  assign imemREN  = ~halted_q;

  assign fd_instr = fd_instr_q;
  assign fd_pc    = fd_pc_q;
  assign fd_npc   = fd_npc_q;
  assign fd_valid = fd_valid_q;

  // Next-PC selection; a halt request on the same edge blocks the update
  always_comb begin
    pc_d = pc_q;
    if (PC_WEN && !halted_q && !halt_in) begin
      case (PCSrc)
        SRC_SEQ:    pc_d = npc;
        SRC_BRANCH: pc_d = branch_target;
        SRC_JUMP:   pc_d = jump_target;
        SRC_JR:     pc_d = jr_target;
        default:    pc_d = npc;
      endcase
    end
  end

  // Sticky halt: only reset clears it
  always_comb begin
    halted_d = halted_q | halt_in;
  end

  // IF/ID latch next state: FLUSH > STALL > NORMAL; unknown encodings hold
  always_comb begin
    fd_instr_d  = fd_instr_q;
    fd_pc_d     = fd_pc_q;
    fd_npc_d    = fd_npc_q;
    fd_valid_d  = fd_valid_q;
    load_valid  = 1'b0;
    load_bubble = 1'b0;
    case (fd_state)
      FLUSH: begin
        // pc/npc deliberately keep their old values on a flush
        fd_instr_d  = 32'd0;
        fd_valid_d  = 1'b0;
        load_bubble = 1'b1;
      end
      NORMAL: begin
        if (ihit && !halted_q) begin
          fd_instr_d = iload;
          fd_pc_d    = pc_q;
          fd_npc_d   = npc;
          fd_valid_d = 1'b1;
          load_valid = 1'b1;
        end else begin
          fd_instr_d  = 32'd0;
          fd_valid_d  = 1'b0;
          load_bubble = 1'b1;
        end
      end
      default: begin
        // STALL and any undefined encoding: hold everything
      end
    endcase
  end

  // PC and halt flag registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_q     <= PC_RESET;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  // IF/ID pipeline latch registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fd_instr_q <= 32'd0;
      fd_pc_q    <= 32'd0;
      fd_npc_q   <= 32'd0;
      fd_valid_q <= 1'b0;
    end else begin
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      fd_npc_q   <= fd_npc_d;
      fd_valid_q <= fd_valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_bubbles_q, perf_bubbles_d;

  // Saturating increment shared by both counters
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counter next state; nothing is counted once halted
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (!halted_q) begin
      if (load_valid)  perf_fetched_d = sat_inc(perf_fetched_q);
      if (load_bubble) perf_bubbles_d = sat_inc(perf_bubbles_q);
    end
  end

  // Performance counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_fetched_q <= 32'd0;
      perf_bubbles_q <= 32'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized traffic,
// checked against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        PC_WEN;
  logic [1:0]  PCSrc;
  logic [31:0] branch_target, jump_target, jr_target;
  pipe_state_t fd_state;
  logic        halt_in;
  logic [31:0] fd_instr, fd_pc, fd_npc;
  logic        fd_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_halted;
  logic [31:0] m_instr, m_fpc, m_fnpc;
  logic        m_valid;
  logic [31:0] m_fet, m_bub;

  fetch_stage #(.PC_RESET(32'h0000_0000), .PC_INCR(32'd4)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .PC_WEN(PC_WEN), .PCSrc(PCSrc),
    .branch_target(branch_target), .jump_target(jump_target), .jr_target(jr_target),
    .fd_state(fd_state), .halt_in(halt_in),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_npc(fd_npc), .fd_valid(fd_valid)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 1'b0;
    m_instr = 0; m_fpc = 0; m_fnpc = 0; m_valid = 1'b0;
    m_fet = 0; m_bub = 0;
  endtask

  // One clock edge: the model applies the fetch rules to the inputs present at the edge,
  // then outputs are sampled 1 time unit later.
  task automatic tick();
    logic [31:0] seq;
    @(posedge CLK);
    seq = m_pc + 32'd4;
    if (fd_state == FLUSH) begin
      m_instr = 0; m_valid = 0;
      if (!m_halted && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
    end else if (fd_state == NORMAL) begin
      if (ihit && !m_halted) begin
        m_instr = iload; m_fpc = m_pc; m_fnpc = seq; m_valid = 1;
        if (m_fet != 32'hFFFF_FFFF) m_fet = m_fet + 1;
      end else begin
        m_instr = 0; m_valid = 0;
        if (!m_halted && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
      end
    end
    if (PC_WEN && !m_halted && !halt_in)
      m_pc = (PCSrc == 2'd1) ? branch_target :
             (PCSrc == 2'd2) ? jump_target :
             (PCSrc == 2'd3) ? jr_target : seq;
    if (halt_in) m_halted = 1'b1;
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic idle_inputs();
    ihit = 0; iload = 0; PC_WEN = 0; PCSrc = 0;
    branch_target = 0; jump_target = 0; jr_target = 0;
    fd_state = NORMAL; halt_in = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #3;
    model_reset();
    checks++;
    if (imemaddr !== 32'h0 || fd_instr !== 0 || fd_pc !== 0 || fd_npc !== 0 || fd_valid !== 0) begin
      failures++;
      $display("FAIL reset_state: addr=%h instr=%h pc=%h npc=%h valid=%b, required all 0",
               imemaddr, fd_instr, fd_pc, fd_npc, fd_valid);
    end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    checks++;
    if (imemREN !== 1'b1) begin
      failures++;
      $display("FAIL reset_ren: imemREN=%b required 1", imemREN);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] words [4];
    ihit = 1; PC_WEN = 1; PCSrc = 0; fd_state = NORMAL;
    for (int i = 0; i < 4; i++) begin
      words[i] = $urandom;
      iload = words[i];
      tick();
      checks++;
      if (imemaddr !== 32'(4 * (i + 1))) begin
        failures++;
        $display("FAIL seq_addr[%0d]: imemaddr=%h required %h", i, imemaddr, 32'(4 * (i + 1)));
      end
      checks++;
      if (fd_pc !== 32'(4 * i) || fd_valid !== 1'b1 || fd_instr !== words[i]) begin
        failures++;
        $display("FAIL seq_latch[%0d]: pc=%h valid=%b instr=%h required pc=%h valid=1 instr=%h",
                 i, fd_pc, fd_valid, fd_instr, 32'(4 * i), words[i]);
      end
    end
  endtask

  task automatic test_miss();
    // pc is 0x10 after the sequential test
    ihit = 0; PC_WEN = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imemaddr !== 32'h10 || fd_valid !== 1'b0) begin
        failures++;
        $display("FAIL miss[%0d]: imemaddr=%h valid=%b required 00000010/0", i, imemaddr, fd_valid);
      end
    end
    ihit = 1; iload = 32'hCAFE_0010;
    tick();
    checks++;
    if (fd_pc !== 32'h10 || fd_npc !== 32'h14 || fd_valid !== 1'b1 || fd_instr !== 32'hCAFE_0010) begin
      failures++;
      $display("FAIL miss_fill: pc=%h npc=%h valid=%b instr=%h required 10/14/1/cafe0010",
               fd_pc, fd_npc, fd_valid, fd_instr);
    end
  endtask

  task automatic test_redirect();
    ihit = 1; PC_WEN = 1; iload = $urandom;
    PCSrc = 1; branch_target = 32'h40;
    tick();
    checks++;
    if (imemaddr !== 32'h40) begin
      failures++; $display("FAIL redir_branch: imemaddr=%h required 00000040", imemaddr);
    end
    PCSrc = 2; jump_target = 32'h80;
    tick();
    checks++;
    if (imemaddr !== 32'h80) begin
      failures++; $display("FAIL redir_jump: imemaddr=%h required 00000080", imemaddr);
    end
    PCSrc = 3; jr_target = 32'h33;
    tick();
    checks++;
    if (imemaddr !== 32'h30) begin
      failures++; $display("FAIL redir_jr: imemaddr=%h required 00000030", imemaddr);
    end
    PCSrc = 0;
    tick();
    checks++;
    if (imemaddr !== 32'h34 || fd_pc !== 32'h33 || fd_npc !== 32'h37) begin
      failures++;
      $display("FAIL redir_seq: imemaddr=%h fd_pc=%h fd_npc=%h required 34/33/37", imemaddr, fd_pc, fd_npc);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] hi, hp, hn;
    ihit = 1; PC_WEN = 1; PCSrc = 0; fd_state = NORMAL; iload = 32'h1234_5678;
    tick();
    hi = fd_instr; hp = fd_pc; hn = fd_npc;
    fd_state = STALL;
    for (int i = 0; i < 2; i++) begin
      iload = $urandom;
      tick();
      checks++;
      if (fd_instr !== 32'h1234_5678 || fd_pc !== hp || fd_npc !== hn || fd_valid !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: instr=%h pc=%h npc=%h valid=%b required %h/%h/%h/1",
                 i, fd_instr, fd_pc, fd_npc, fd_valid, hi, hp, hn);
      end
    end
    fd_state = FLUSH; iload = $urandom;
    tick();
    checks++;
    if (fd_instr !== 32'h0 || fd_valid !== 1'b0 || fd_pc !== hp || fd_npc !== hn) begin
      failures++;
      $display("FAIL flush: instr=%h valid=%b pc=%h npc=%h required 0/0/%h/%h",
               fd_instr, fd_valid, fd_pc, fd_npc, hp, hn);
    end
    // Undefined encoding behaves as STALL
    fd_state = NORMAL; iload = 32'hABCD_0001;
    tick();
    fd_state = pipe_state_t'(2'd3); iload = $urandom;
    tick();
    checks++;
    if (fd_instr !== 32'hABCD_0001 || fd_valid !== 1'b1) begin
      failures++;
      $display("FAIL undef_state: instr=%h valid=%b required abcd0001/1", fd_instr, fd_valid);
    end
    fd_state = NORMAL;
  endtask

  task automatic test_halt();
    logic [31:0] addr0;
    ihit = 1; PC_WEN = 1; PCSrc = 0; fd_state = NORMAL;
    addr0 = imemaddr;
    halt_in = 1;
    tick();
    halt_in = 0;
    checks++;
    if (imemaddr !== addr0 || imemREN !== 1'b0) begin
      failures++;
      $display("FAIL halt_entry: imemaddr=%h ren=%b required %h/0", imemaddr, imemREN, addr0);
    end
    for (int i = 0; i < 3; i++) begin
      iload = $urandom;
      tick();
      checks++;
      if (imemaddr !== addr0 || imemREN !== 1'b0 || fd_valid !== 1'b0) begin
        failures++;
        $display("FAIL halted[%0d]: imemaddr=%h ren=%b valid=%b required %h/0/0",
                 i, imemaddr, imemREN, fd_valid, addr0);
      end
    end
    // Asynchronous reset mid-halt, checked before any clock edge
    nRST = 1'b0;
    #2;
    model_reset();
    checks++;
    if (imemaddr !== 32'h0 || imemREN !== 1'b1) begin
      failures++;
      $display("FAIL halt_reset: imemaddr=%h ren=%b required 0/1", imemaddr, imemREN);
    end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_wrap();
    ihit = 1; PC_WEN = 1; fd_state = NORMAL;
    PCSrc = 2; jump_target = 32'hFFFF_FFFC;
    tick();
    PCSrc = 0;
    tick();
    checks++;
    if (imemaddr !== 32'h0 || fd_pc !== 32'hFFFF_FFFC || fd_npc !== 32'h0) begin
      failures++;
      $display("FAIL wrap: imemaddr=%h fd_pc=%h fd_npc=%h required 0/fffffffc/0", imemaddr, fd_pc, fd_npc);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    idle_inputs();
    do_reset();
    ihit = 1; PC_WEN = 1; fd_state = NORMAL;
    for (int i = 0; i < 5; i++) begin
      iload = $urandom;
      tick();
    end
    ihit = 0;
    tick();
    fd_state = FLUSH;
    tick();
    fd_state = NORMAL;
    checks++;
    if (perf_fetched !== 32'd5 || perf_bubbles !== 32'd2) begin
      failures++;
      $display("FAIL perf_counts: fetched=%0d bubbles=%0d required 5/2", perf_fetched, perf_bubbles);
    end
    halt_in = 1;
    tick();
    halt_in = 0;
    ihit = 1;
    tick();
    tick();
    checks++;
    if (perf_fetched !== m_fet || perf_bubbles !== m_bub) begin
      failures++;
      $display("FAIL perf_halted: fetched=%0d bubbles=%0d required %0d/%0d",
               perf_fetched, perf_bubbles, m_fet, m_bub);
    end
  endtask
`endif

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      ihit = ($urandom_range(0, 3) != 0);
      iload = $urandom;
      PC_WEN = ($urandom_range(0, 3) != 0);
      PCSrc = 2'($urandom_range(0, 3));
      branch_target = $urandom; jump_target = $urandom; jr_target = $urandom;
      fd_state = pipe_state_t'(2'($urandom_range(0, 3)));
      halt_in = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 59) == 0) begin
        do_reset();
        halt_in = 0;
      end
      tick();
      checks++;
      if (imemaddr !== {m_pc[31:2], 2'b00} || imemREN !== !m_halted) begin
        failures++;
        $display("FAIL rand_fetch[%0d]: imemaddr=%h ren=%b required %h/%b",
                 i, imemaddr, imemREN, {m_pc[31:2], 2'b00}, !m_halted);
      end
      checks++;
      if (fd_instr !== m_instr || fd_pc !== m_fpc || fd_npc !== m_fnpc || fd_valid !== m_valid) begin
        failures++;
        $display("FAIL rand_latch[%0d]: instr=%h pc=%h npc=%h valid=%b required %h/%h/%h/%b",
                 i, fd_instr, fd_pc, fd_npc, fd_valid, m_instr, m_fpc, m_fnpc, m_valid);
      end
`ifdef FETCH_PERF_EN
      checks++;
      if (perf_fetched !== m_fet || perf_bubbles !== m_bub) begin
        failures++;
        $display("FAIL rand_perf[%0d]: fetched=%0d bubbles=%0d required %0d/%0d",
                 i, perf_fetched, perf_bubbles, m_fet, m_bub);
      end
`endif
    end
  endtask

  initial begin
    nRST = 1'b1;
    model_reset();
    test_reset();
    test_sequential();
    test_miss();
    test_redirect();
    test_stall_flush();
    test_halt();
    test_wrap();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
